// File: rtl/imm_pkg.sv
// Shared types and defaults for the immediate-generator pipeline.
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    ImmR  = 3'b000,
    ImmI  = 3'b001,
    ImmI2 = 3'b010,
    ImmB  = 3'b011,
    ImmU  = 3'b100,
    ImmJ  = 3'b101,
    ImmS  = 3'b110,
    ImmZ  = 3'b111
  } imm_type_e;

endpackage

// File: rtl/imm_fifo.sv
// Ready/valid FIFO holding decoded immediates plus tags; flush beats push and pop.
module imm_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  localparam logic [CntW-1:0] Full = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  assign ready_o = (cnt_q < Full);
  assign valid_o = (cnt_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign count_o = cnt_q;
  // Empty queue (including reset) presents zeros rather than stale storage.
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PtrW'(1);
      if (pop)  rd_d = rd_q + PtrW'(1);
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a tagged output queue.
// Define IMM_GEN_ZIMM_EN to decode type 111 as the CSR zimm immediate.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       valid_in,
  output logic                       ready_o,
  input  logic [24:0]                instr_in,
  input  logic [2:0]                 imm_type_in,
  input  logic [TAG_W-1:0]           tag_in,
  input  logic                       flush_in,
  output logic                       valid_o,
  input  logic                       ready_in,
  output logic [XLEN-1:0]            imm_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  // Indexed with architectural bit numbers so the format slices read naturally.
  logic [31:7] ins;
  assign ins = instr_in;

  logic signed [11:0] i_imm, s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;
  logic [XLEN-1:0]    imm_d;

  assign i_imm = $signed(ins[31:20]);
  assign s_imm = $signed({ins[31:25], ins[11:7]});
  assign b_imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
  assign u_imm = $signed({ins[31:12], 12'b0});
  assign j_imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});

  always_comb begin
    imm_d = '0;
    unique case (imm_type_e'(imm_type_in))
      ImmR:        imm_d = '0;
      ImmI, ImmI2: imm_d = XLEN'(i_imm);
      ImmB:        imm_d = XLEN'(b_imm);
      ImmU:        imm_d = XLEN'(u_imm);
      ImmJ:        imm_d = XLEN'(j_imm);
      ImmS:        imm_d = XLEN'(s_imm);
`ifdef IMM_GEN_ZIMM_EN
      ImmZ:        imm_d = XLEN'(ins[19:15]);
`else
      ImmZ:        imm_d = XLEN'(i_imm);
`endif
    endcase
  end

  logic [TAG_W+XLEN-1:0] head;

  imm_fifo #(
    .Width(TAG_W + XLEN),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .valid_i(valid_in),
    .ready_o(ready_o),
    .data_i ({tag_in, imm_d}),
    .flush_i(flush_in),
    .valid_o(valid_o),
    .ready_i(ready_in),
    .data_o (head),
    .count_o(count_o)
  );

  assign imm_o = head[XLEN-1:0];
  assign tag_o = head[TAG_W+XLEN-1:XLEN];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 main instance, XLEN=64 for J-type).
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_in, ready_in, flush_in;
  logic [24:0] instr_in;
  logic [2:0]  imm_type_in;
  logic [3:0]  tag_in;
  logic        ready_o, valid_o;
  logic [31:0] imm_o;
  logic [3:0]  tag_o;
  logic [2:0]  count_o;

  logic        v64_in;
  logic [24:0] instr64_in;
  logic [2:0]  type64_in;
  logic        ready64_o, valid64_o;
  logic [63:0] imm64_o;
  logic [3:0]  tag64_o;
  logic [2:0]  count64_o;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe u_dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .valid_in   (valid_in),
    .ready_o    (ready_o),
    .instr_in   (instr_in),
    .imm_type_in(imm_type_in),
    .tag_in     (tag_in),
    .flush_in   (flush_in),
    .valid_o    (valid_o),
    .ready_in   (ready_in),
    .imm_o      (imm_o),
    .tag_o      (tag_o),
    .count_o    (count_o)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .valid_in   (v64_in),
    .ready_o    (ready64_o),
    .instr_in   (instr64_in),
    .imm_type_in(type64_in),
    .tag_in     (4'h0),
    .flush_in   (1'b0),
    .valid_o    (valid64_o),
    .ready_in   (1'b0),
    .imm_o      (imm64_o),
    .tag_o      (tag64_o),
    .count_o    (count64_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] word, input logic [2:0] t, input logic [3:0] tg);
    valid_in    = 1'b1;
    instr_in    = word[31:7];
    imm_type_in = t;
    tag_in      = tg;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; flush_in = 1'b0;
    instr_in = '0; imm_type_in = '0; tag_in = '0;
    v64_in = 1'b0; instr64_in = '0; type64_in = '0;
    #1;
    check("rst_count", count_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_imm", imm_o, 0);
    check("rst_tag", tag_o, 0);
    #11 rst_n = 1'b1;
    tick();

    // I-type on the 32-bit instance, J-type on the 64-bit instance in parallel.
    drive(32'hFFF0_0093, 3'b001, 4'd3);
    w = 32'h8000_006F;
    v64_in = 1'b1; instr64_in = w[31:7]; type64_in = 3'b101;
    check("i_not_early", valid_o, 0);
    tick();
    valid_in = 1'b0; v64_in = 1'b0;
    check("i_valid", valid_o, 1);
    check("i_imm", imm_o, 32'hFFFF_FFFF);
    check("i_tag", tag_o, 3);
    check("j64_imm", imm64_o, 64'hFFFF_FFFF_FFF0_0000);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check("i_pop_empty", valid_o, 0);

    // B then U, with instr_in changed after queuing.
    drive(32'hFE00_0EE3, 3'b011, 4'd1);
    tick();
    drive(32'h1234_50B7, 3'b100, 4'd2);
    tick();
    valid_in = 1'b0; instr_in = '1; imm_type_in = 3'b001;
    check("bu_count", count_o, 2);
    check("b_imm", imm_o, 32'hFFFF_FFFC);
    ready_in = 1'b1;
    tick();
    check("u_imm", imm_o, 32'h1234_5000);
    check("u_tag", tag_o, 2);
    tick();
    ready_in = 1'b0;
    check("bu_drained", count_o, 0);

    // Fill past capacity under backpressure.
    for (int i = 0; i < 5; i++) begin
      drive(32'h0010_0093, 3'b001, 4'(i));
      if (i == 4) check("full_ready", ready_o, 0);
      tick();
    end
    valid_in = 1'b0;
    check("full_count", count_o, 4);
    check("full_head_tag", tag_o, 0);
    check("full_head_imm", imm_o, 1);
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", tag_o, 64'(i));
      tick();
    end
    ready_in = 1'b0;
    check("drain_empty", valid_o, 0);

    // Simultaneous push/pop keeps count and order; pointers have wrapped here.
    drive(32'h0010_0093, 3'b001, 4'd10);
    tick();
    drive(32'h0020_0093, 3'b010, 4'd11);
    ready_in = 1'b1;
    tick();
    check("pp_count", count_o, 1);
    check("pp_tag", tag_o, 11);
    check("pp_imm", imm_o, 2);
    ready_in = 1'b0;
    drive(32'h00A1_2423, 3'b110, 4'd12);
    tick();
    check("pre_flush_count", count_o, 2);

    // Flush wins over same-cycle push and pop.
    drive(32'h0030_0093, 3'b001, 4'd13);
    ready_in = 1'b1; flush_in = 1'b1;
    tick();
    flush_in = 1'b0; ready_in = 1'b0; valid_in = 1'b0;
    check("flush_count", count_o, 0);
    check("flush_valid", valid_o, 0);

    // S-type, zero type, and type 111.
    drive(32'h00A1_2423, 3'b110, 4'd4);
    tick();
    drive(32'hFFFF_FFFF, 3'b000, 4'd5);
    tick();
    drive(32'h800F_8073, 3'b111, 4'd6);
    tick();
    valid_in = 1'b0;
    ready_in = 1'b1;
    check("s_imm", imm_o, 8);
    tick();
    check("zero_imm", imm_o, 0);
    tick();
`ifdef IMM_GEN_ZIMM_EN
    check("t7_zimm", imm_o, 32'h0000_001F);
`else
    check("t7_itype", imm_o, 32'hFFFF_F800);
`endif
    ready_in = 1'b0;

    // Reset mid-stream discards contents immediately.
    drive(32'h0040_0093, 3'b001, 4'd7);
    tick();
    valid_in = 1'b0;
    check("pre_rst_count", count_o, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_imm", imm_o, 0);
    check("mid_rst_ready", ready_o, 1);
    #3 rst_n = 1'b1;
    tick();
    drive(32'h0050_0093, 3'b001, 4'd9);
    tick();
    valid_in = 1'b0;
    check("post_rst_tag", tag_o, 9);
    check("post_rst_imm", imm_o, 5);
    check("post_rst_count", count_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, output queue entries; power of two, minimum 2.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each immediate.
REQ-004 SHALL have port clk_in, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1, upstream request valid.
REQ-007 SHALL have port ready_o, output, 1, block can accept a request.
REQ-008 SHALL have port instr_in, input, 25, instruction bits [31:7].
REQ-009 SHALL have port imm_type_in, input, 3, immediate format select.
REQ-010 SHALL have port tag_in, input, TAG_W, sideband tag.
REQ-011 SHALL have port flush_in, input, 1, synchronous queue discard.
REQ-012 SHALL have port valid_o, output, 1, head entry valid.
REQ-013 SHALL have port ready_in, input, 1, downstream accepts head.
REQ-014 SHALL have port imm_o, output, XLEN, head immediate.
REQ-015 SHALL have port tag_o, output, TAG_W, head tag.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH+1), occupied entries.

Function
REQ-017 SHALL perform a push when valid_in and ready_o are both high at a rising edge, and a pop when valid_o and ready_in are both high.
REQ-018 SHALL drive ready_o = (count_o < DEPTH) with no same-cycle pass-through when full; valid_o = (count_o != 0).
REQ-019 SHALL present a pushed entry at the head no earlier than the cycle after the push (latency 1 when empty).
REQ-020 SHALL decode imm_type_in as follows: 000 gives zero; 001 and 010 give I-type; 011 gives B-type; 100 gives U-type; 101 gives J-type; 110 gives S-type; 111 gives I-type unless REQ-030 applies.
REQ-021 SHALL sign-extend every signed format from instr bit 31 to XLEN; U-type on XLEN=64 SHALL sign-extend from bit 31.
REQ-022 SHALL compute the immediate at push time and store it, so later changes on instr_in never alter queued entries.
REQ-023 SHALL on a simultaneous push and pop with 0 < count < DEPTH leave the count unchanged and preserve FIFO order.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL on flush_in empty the queue at the next edge (count 0, valid_o 0); flush overrides a same-cycle push and pop.
REQ-026 SHALL hold imm_o and tag_o stable while valid_o is high and ready_in is low.

Reset
REQ-027 SHALL, on rst_n_in low, asynchronously clear count_o, valid_o and both pointers to 0, and drive ready_o to 1.
REQ-028 SHALL drive imm_o and tag_o to 0 during reset; queue storage need not reset.
REQ-029 SHALL discard all queued entries on reset asserted mid-operation; the first push after deassertion SHALL appear as the head.

Configuration
REQ-030 SHALL, with IMM_GEN_ZIMM_EN defined, decode type 111 as the CSR zimm immediate: instr[19:15] zero-extended to XLEN.
REQ-031 SHALL, without IMM_GEN_ZIMM_EN defined, decode type 111 as an I-type immediate.

Structure
REQ-032 SHALL define the imm_type_e enum (R, I, I2, B, U, J, S, Z) and XLEN_DEFAULT in package imm_pkg.
REQ-033 SHALL implement storage, pointers and count in sub-module imm_fifo; decode SHALL be combinational before the push.

Verification
REQ-034 SHALL cover I-type: push instr 0xFFF00093, type 001, tag 3 -> next cycle valid_o=1, imm_o=0xFFFFFFFF, tag_o=3.
REQ-035 SHALL cover B-type and U-type: push 0xFE000EE3 with type 011, then 0x123450B7 with type 100 -> pops give 0xFFFFFFFC then 0x12345000, in order.
REQ-036 SHALL cover full and backpressure: ready_in=0 and DEPTH+1 pushes attempted -> count_o=DEPTH, ready_o=0, extra push dropped, head stable.
REQ-037 SHALL cover J-type on XLEN=64: instr 0x8000006F, type 101 -> imm_o=0xFFFFFFFFFFF00000.
REQ-038 SHALL cover flush and reset: flush_in together with push at count 2 -> count 0 next cycle; reset mid-stream -> valid_o=0 immediately.
REQ-039 SHALL cover type 111 with instr[19:15]=0x1F and instr[31]=1 -> 0x0000001F with IMM_GEN_ZIMM_EN defined, 0xFFFFF800-based sign-extended I-type without it.
